core_arf_scb: RTL and testbench

// - Register scoreboard + in-order issue gate in front of core_arf for the superscalar TOY core.
// - Tracks one busy bit per architectural register (16 x 16-bit ARF) from issue until writeback.
// - Grants the longest hazard-free prefix of issue slots each cycle; stalls on RAW/WAW hazards.
// - Clears all pending state on pipeline flush; keeps a stall counter and a sticky error flag.

---
 rtl/core_scb_pkg.sv | 44 ++++
 rtl/core_scb_hzd.sv | 26 ++
 rtl/core_arf_scb.sv | 152 +++++++++++++++
 tb/tb_core_arf_scb.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/core_scb_pkg.sv
// core_scb_pkg -- shared types and sizing for the core_arf register scoreboard.
//   reg_idx_t  : architectural register index (R0..R15, R0 hard-wired zero)
//   iss_slot_t : decoded register usage of one issue slot
//   reg_mask() : one-hot register mask with R0 suppressed
// Issue/writeback widths follow the core's execute + memory pipe counts
// (SSC_EX / SSC_MEM); both fall back to 1 when the core does not define them.

`ifndef SSC_EX
`define SSC_EX 1
`endif
`ifndef SSC_MEM
`define SSC_MEM 1
`endif

package core_scb_pkg;

  localparam int NREG        = 16;
  localparam int SCB_ISSUE_W = `SSC_EX + `SSC_MEM;
  localparam int SCB_WB_W    = `SSC_EX + `SSC_MEM;

  typedef logic [3:0] reg_idx_t;

  typedef struct packed {
    logic src_a;
    logic src_b;
    logic dst;
  } slot_use_t;

  typedef struct packed {
    reg_idx_t  src_a;
    reg_idx_t  src_b;
    reg_idx_t  dst;
    slot_use_t uses;
  } iss_slot_t;

  // R0 never appears in any mask: it is never busy and never a hazard.
  function automatic logic [NREG-1:0] reg_mask(input reg_idx_t idx, input logic en);
    logic [NREG-1:0] m;
    m = '0;
    if (en && (idx != '0)) m[idx] = 1'b1;
    return m;
  endfunction

endpackage

// File: rtl/core_scb_hzd.sv
// core_scb_hzd -- combinational hazard check for one issue slot.
//   slot      in  iss_slot_t   decoded sources/destination of this slot
//   busy_eff  in  NREG         registers with an outstanding writer
//   older_dst in  NREG         used destinations of all older slots this cycle
//   hazard    out 1            slot must not issue (RAW or WAW)

module core_scb_hzd
  import core_scb_pkg::*;
(
  input  iss_slot_t       slot,
  input  logic [NREG-1:0] busy_eff,
  input  logic [NREG-1:0] older_dst,
  output logic            hazard
);

  logic [NREG-1:0] blocked;

  always_comb begin
    blocked    = busy_eff | older_dst;
    blocked[0] = 1'b0;
    hazard     = (slot.uses.src_a & blocked[slot.src_a])
               | (slot.uses.src_b & blocked[slot.src_b])
               | (slot.uses.dst   & blocked[slot.dst]);
  end

endmodule

// File: rtl/core_arf_scb.sv
// core_arf_scb -- register scoreboard and in-order issue gate for core_arf.
// One busy bit per architectural register, set when a writer issues and
// cleared on its writeback. Each cycle the longest hazard-free prefix of the
// issue slots is granted (slot 0 oldest).
// Ports:
//   clk_i, arst_ni                 clock, async active-low reset
//   iss_vld_i / iss_*_i            per-slot valid, source/destination indices and use flags
//   iss_gnt_o                      combinational grant, contiguous from bit 0
//   wb_en_i, wb_addr_i             writeback ports (mirror core_arf write ports)
//   flush_i                        squash everything in flight
//   busy_o                         registered busy mask
//   stall_cnt_o                    saturating count of cycles with a valid slot left ungranted
//   err_o                          sticky protocol error (stray or duplicate writeback)
// Build option: CORE_SCB_WB_BYPASS_EN lets a consumer issue in the same cycle
// its source is written back (execute must forward the wb data).

module core_arf_scb
  import core_scb_pkg::*;
#(
  parameter int ISSUE_W = SCB_ISSUE_W,
  parameter int WB_W    = SCB_WB_W
) (
  input  logic                 clk_i,
  input  logic                 arst_ni,
  input  logic [ISSUE_W-1:0]   iss_vld_i,
  input  logic [ISSUE_W*4-1:0] iss_src_a_i,
  input  logic [ISSUE_W-1:0]   iss_src_a_use_i,
  input  logic [ISSUE_W*4-1:0] iss_src_b_i,
  input  logic [ISSUE_W-1:0]   iss_src_b_use_i,
  input  logic [ISSUE_W*4-1:0] iss_dst_i,
  input  logic [ISSUE_W-1:0]   iss_dst_use_i,
  output logic [ISSUE_W-1:0]   iss_gnt_o,
  input  logic [WB_W-1:0]      wb_en_i,
  input  logic [WB_W*4-1:0]    wb_addr_i,
  input  logic                 flush_i,
  output logic [NREG-1:0]      busy_o,
  output logic [15:0]          stall_cnt_o,
  output logic                 err_o
);

  logic [NREG-1:0] busy_q;
  logic [NREG-1:0] busy_eff;
  logic [NREG-1:0] clr;
  logic [NREG-1:0] set;
  logic [NREG-1:0] older_acc;
  logic [15:0]     stall_q;
  logic            err_q;
  logic            err_det;
  logic            gnt_run;

  iss_slot_t        slot      [ISSUE_W];
  logic [NREG-1:0]  older_dst [ISSUE_W];
  logic [ISSUE_W-1:0] hazard;
  logic [ISSUE_W-1:0] gnt;

  always_comb begin
    for (int k = 0; k < ISSUE_W; k++) begin
      slot[k].src_a      = iss_src_a_i[k*4 +: 4];
      slot[k].src_b      = iss_src_b_i[k*4 +: 4];
      slot[k].dst        = iss_dst_i[k*4 +: 4];
      slot[k].uses.src_a = iss_src_a_use_i[k];
      slot[k].uses.src_b = iss_src_b_use_i[k];
      slot[k].uses.dst   = iss_dst_use_i[k];
    end
  end

  always_comb begin
    clr = '0;
    for (int p = 0; p < WB_W; p++) begin
      clr |= reg_mask(wb_addr_i[p*4 +: 4], wb_en_i[p]);
    end
  end

`ifdef CORE_SCB_WB_BYPASS_EN
  assign busy_eff = busy_q & ~clr;
`else
  assign busy_eff = busy_q;
`endif

  // Older-slot destinations are collected regardless of validity: a younger
  // slot can only be granted if every older slot was, so invalid older slots
  // never matter.
  always_comb begin
    older_acc = '0;
    for (int k = 0; k < ISSUE_W; k++) begin
      older_dst[k] = older_acc;
      older_acc   |= reg_mask(slot[k].dst, slot[k].uses.dst);
    end
  end

  for (genvar k = 0; k < ISSUE_W; k++) begin : g_hzd
    core_scb_hzd u_hzd (
      .slot      (slot[k]),
      .busy_eff  (busy_eff),
      .older_dst (older_dst[k]),
      .hazard    (hazard[k])
    );
  end

  // Grant chain: the first blocked slot stops everything younger.
  // Reset gating keeps grants low while busy state is being held cleared.
  always_comb begin
    gnt     = '0;
    gnt_run = arst_ni & ~flush_i;
    for (int k = 0; k < ISSUE_W; k++) begin
      gnt_run = gnt_run & iss_vld_i[k] & ~hazard[k];
      gnt[k]  = gnt_run;
    end
  end

  always_comb begin
    set = '0;
    for (int k = 0; k < ISSUE_W; k++) begin
      set |= reg_mask(slot[k].dst, gnt[k] & slot[k].uses.dst);
    end
  end

  always_comb begin
    err_det = 1'b0;
    for (int p = 0; p < WB_W; p++) begin
      if (wb_en_i[p] && (wb_addr_i[p*4 +: 4] != 4'd0) && !busy_q[wb_addr_i[p*4 +: 4]])
        err_det = 1'b1;
      for (int q = p + 1; q < WB_W; q++) begin
        if (wb_en_i[p] && wb_en_i[q] && (wb_addr_i[p*4 +: 4] != 4'd0)
            && (wb_addr_i[p*4 +: 4] == wb_addr_i[q*4 +: 4]))
          err_det = 1'b1;
      end
    end
  end

  // Set is ORed after the clear so a register retired and re-issued in the
  // same cycle stays busy for its new writer.
  always_ff @(posedge clk_i or negedge arst_ni) begin
    if (!arst_ni) begin
      busy_q  <= '0;
      stall_q <= '0;
      err_q   <= 1'b0;
    end else begin
      busy_q <= flush_i ? '0 : ((busy_q & ~clr) | set);
      if (!flush_i && (|(iss_vld_i & ~gnt)) && (stall_q != 16'hFFFF))
        stall_q <= stall_q + 16'd1;
      if (err_det)
        err_q <= 1'b1;
    end
  end

  assign iss_gnt_o   = gnt;
  assign busy_o      = busy_q;
  assign stall_cnt_o = stall_q;
  assign err_o       = err_q;

endmodule

// File: tb/tb_core_arf_scb.sv
module tb_core_arf_scb;
  import core_scb_pkg::*;

  localparam int IW = SCB_ISSUE_W;
  localparam int WW = SCB_WB_W;

`ifdef CORE_SCB_WB_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              arst_ni;
  logic [IW-1:0]     iss_vld;
  logic [IW*4-1:0]   iss_src_a;
  logic [IW-1:0]     iss_src_a_use;
  logic [IW*4-1:0]   iss_src_b;
  logic [IW-1:0]     iss_src_b_use;
  logic [IW*4-1:0]   iss_dst;
  logic [IW-1:0]     iss_dst_use;
  logic [IW-1:0]     iss_gnt;
  logic [WW-1:0]     wb_en;
  logic [WW*4-1:0]   wb_addr;
  logic              flush;
  logic [NREG-1:0]   busy;
  logic [15:0]       stall_cnt;
  logic              err;

  core_arf_scb dut (
    .clk_i           (clk),
    .arst_ni         (arst_ni),
    .iss_vld_i       (iss_vld),
    .iss_src_a_i     (iss_src_a),
    .iss_src_a_use_i (iss_src_a_use),
    .iss_src_b_i     (iss_src_b),
    .iss_src_b_use_i (iss_src_b_use),
    .iss_dst_i       (iss_dst),
    .iss_dst_use_i   (iss_dst_use),
    .iss_gnt_o       (iss_gnt),
    .wb_en_i         (wb_en),
    .wb_addr_i       (wb_addr),
    .flush_i         (flush),
    .busy_o          (busy),
    .stall_cnt_o     (stall_cnt),
    .err_o           (err)
  );

  always #5 clk = ~clk;

  int n_total = 0;
  int n_pass  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
  endtask

  // ---------------- behavioural model ----------------
  bit          m_busy  [NREG];
  bit          claimed [NREG];
  bit          seen    [NREG];
  int          m_stall = 0;
  bit          m_err   = 1'b0;
  logic [IW-1:0] eg;
  bit          run;

  function automatic logic [15:0] pack_busy();
    logic [15:0] m = '0;
    for (int r = 0; r < NREG; r++) m[r] = m_busy[r];
    return m;
  endfunction

  function automatic bit wb_hits(int r);
    for (int p = 0; p < WW; p++)
      if (wb_en[p] && int'(wb_addr[p*4 +: 4]) == r) return 1'b1;
    return 1'b0;
  endfunction

  function automatic bit blocked(int r);
    bit b;
    if (r == 0) return 1'b0;
    b = m_busy[r];
    if (BYP && wb_hits(r)) b = 1'b0;
    return b || claimed[r];
  endfunction

  always @(negedge clk) begin
    if (!arst_ni) begin
      chk("rst_gnt", 32'(iss_gnt), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_stall", 32'(stall_cnt), 32'd0);
      chk("rst_err", 32'(err), 32'd0);
      for (int r = 0; r < NREG; r++) m_busy[r] = 1'b0;
      m_stall = 0;
      m_err   = 1'b0;
    end else begin
      chk("busy", 32'(busy), 32'(pack_busy()));
      chk("stall", 32'(stall_cnt), 32'(m_stall));
      chk("err", 32'(err), 32'(m_err));
      for (int r = 0; r < NREG; r++) begin claimed[r] = 1'b0; seen[r] = 1'b0; end
      eg  = '0;
      run = !flush;
      for (int k = 0; k < IW; k++) begin
        int sa, sb, d;
        sa = int'(iss_src_a[k*4 +: 4]);
        sb = int'(iss_src_b[k*4 +: 4]);
        d  = int'(iss_dst[k*4 +: 4]);
        if (run && iss_vld[k] && !(iss_src_a_use[k] && blocked(sa))
            && !(iss_src_b_use[k] && blocked(sb)) && !(iss_dst_use[k] && blocked(d)))
          eg[k] = 1'b1;
        else
          run = 1'b0;
        if (iss_dst_use[k] && d != 0) claimed[d] = 1'b1;
      end
      chk("gnt", 32'(iss_gnt), 32'(eg));
      for (int p = 0; p < WW; p++) begin
        int a;
        a = int'(wb_addr[p*4 +: 4]);
        if (wb_en[p] && a != 0) begin
          if (!m_busy[a] || seen[a]) m_err = 1'b1;
          seen[a] = 1'b1;
        end
      end
      if (!flush && ((iss_vld & ~eg) != '0) && m_stall < 65535) m_stall++;
      if (flush) begin
        for (int r = 0; r < NREG; r++) m_busy[r] = 1'b0;
      end else begin
        for (int r = 0; r < NREG; r++) if (seen[r]) m_busy[r] = 1'b0;
        for (int k = 0; k < IW; k++)
          if (eg[k] && iss_dst_use[k] && iss_dst[k*4 +: 4] != 4'd0)
            m_busy[int'(iss_dst[k*4 +: 4])] = 1'b1;
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic idle();
    iss_vld = '0; iss_src_a = '0; iss_src_a_use = '0; iss_src_b = '0;
    iss_src_b_use = '0; iss_dst = '0; iss_dst_use = '0;
    wb_en = '0; wb_addr = '0; flush = 1'b0;
  endtask

  task automatic slot(input int k, input int sa, input bit ua, input int sb, input bit ub,
                      input int d, input bit ud);
    iss_vld[k] = 1'b1;
    iss_src_a[k*4 +: 4] = 4'(sa); iss_src_a_use[k] = ua;
    iss_src_b[k*4 +: 4] = 4'(sb); iss_src_b_use[k] = ub;
    iss_dst[k*4 +: 4]   = 4'(d);  iss_dst_use[k]   = ud;
  endtask

  task automatic wb(input int p, input int a);
    wb_en[p] = 1'b1;
    wb_addr[p*4 +: 4] = 4'(a);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  int s_base;
  int n;

  initial begin
    for (int r = 0; r < NREG; r++) m_busy[r] = 1'b0;
    arst_ni = 1'b0;
    idle();
    slot(0, 0, 0, 0, 0, 0, 0);
    #1 chk("gnt_in_reset", 32'(iss_gnt), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    chk("reset_busy", 32'(busy), 32'h0);
    chk("reset_stall", 32'(stall_cnt), 32'h0);
    chk("reset_err", 32'(err), 32'h0);
    arst_ni = 1'b1;

    // wb to R0 is ignored, no error
    idle(); wb(0, 0); tick();
    chk("wb_r0_err", 32'(err), 32'h0);

    // RAW on R3, released by writeback
    idle(); slot(0, 0, 0, 0, 0, 3, 1);
    #1 chk("r3_issue_gnt", 32'(iss_gnt), 32'h1);
    tick();
    chk("r3_busy", 32'(busy), 32'h0008);
    idle(); slot(0, 3, 1, 0, 0, 0, 0);
    repeat (3) begin
      #1 chk("r3_stall_gnt", 32'(iss_gnt), 32'h0);
      tick();
    end
    chk("r3_stall_cnt", 32'(stall_cnt), 32'd3);
    wb(0, 3);
    #1 chk("r3_wb_gnt", 32'(iss_gnt), BYP ? 32'h1 : 32'h0);
    tick();
    idle(); slot(0, 3, 1, 0, 0, 0, 0);
    #1 chk("r3_after_wb_gnt", 32'(iss_gnt), 32'h1);
    tick();
    s_base = BYP ? 3 : 4;
    chk("r3_stall_final", 32'(stall_cnt), 32'(s_base));
    chk("r3_err", 32'(err), 32'h0);

    // same-cycle RAW between slots
    idle(); slot(0, 0, 0, 0, 0, 5, 1); slot(1, 0, 0, 5, 1, 0, 0);
    #1 chk("r5_pair_gnt", 32'(iss_gnt), 32'h1);
    tick();
    chk("r5_busy", 32'(busy), 32'h0020);
    chk("r5_stall", 32'(stall_cnt), 32'(s_base + 1));
    idle(); wb(0, 5); tick();

    // in-order: slot0 blocked on R7 blocks independent slot1
    idle(); slot(0, 0, 0, 0, 0, 7, 1); tick();
    chk("r7_busy", 32'(busy), 32'h0080);
    idle(); slot(0, 7, 1, 0, 0, 0, 0); slot(1, 1, 1, 0, 0, 2, 1);
    #1 chk("r7_noskip_gnt", 32'(iss_gnt), 32'h0);
    tick();
    idle(); wb(0, 7); tick();
    chk("r7_cleared", 32'(busy), 32'h0);

    // flush beats writeback and issue
    idle(); slot(0, 0, 0, 0, 0, 4, 1); slot(1, 0, 0, 0, 0, 5, 1);
    #1 chk("f0_gnt_a", 32'(iss_gnt), 32'h3);
    tick();
    idle(); slot(0, 0, 0, 0, 0, 6, 1); slot(1, 0, 0, 0, 0, 7, 1); tick();
    chk("f0_busy", 32'(busy), 32'h00F0);
    idle(); flush = 1'b1; wb(0, 4); slot(0, 1, 1, 0, 0, 2, 1); slot(1, 0, 0, 0, 0, 3, 1);
    #1 chk("flush_gnt", 32'(iss_gnt), 32'h0);
    tick();
    chk("flush_busy", 32'(busy), 32'h0);
    chk("flush_err", 32'(err), 32'h0);
    chk("flush_stall", 32'(stall_cnt), 32'(s_base + 2));

    // stray writeback sets sticky error
    idle(); wb(0, 9); tick();
    chk("stray_wb_err", 32'(err), 32'h1);
    idle(); flush = 1'b1; tick();
    chk("err_after_flush", 32'(err), 32'h1);
    idle(); slot(0, 0, 0, 0, 0, 0, 1);
    #1 chk("r0_dst_gnt", 32'(iss_gnt), 32'h1);
    tick();
    chk("r0_not_busy", 32'(busy), 32'h0);

    // stall counter saturation
    idle(); slot(0, 0, 0, 0, 0, 1, 1); tick();
    chk("sat_busy", 32'(busy), 32'h0002);
    idle(); slot(0, 1, 1, 0, 0, 0, 0);
    n = 0;
    while (m_stall != 32'hFFFE && n < 70000) begin
      tick();
      n++;
    end
    chk("stall_fffe", 32'(stall_cnt), 32'hFFFE);
    repeat (3) tick();
    chk("stall_sat", 32'(stall_cnt), 32'hFFFF);

    // asynchronous reset mid-run
    arst_ni = 1'b0;
    #1;
    chk("midrst_busy", 32'(busy), 32'h0);
    chk("midrst_stall", 32'(stall_cnt), 32'h0);
    chk("midrst_err", 32'(err), 32'h0);
    chk("midrst_gnt", 32'(iss_gnt), 32'h0);
    tick();
    arst_ni = 1'b1;
    idle(); tick();

    // duplicate writeback on two ports
    idle(); slot(0, 0, 0, 0, 0, 2, 1); tick();
    chk("dup_busy", 32'(busy), 32'h0004);
    chk("dup_err_before", 32'(err), 32'h0);
    idle(); wb(0, 2); wb(1, 2); tick();
    chk("dup_err", 32'(err), 32'h1);
    chk("dup_busy_clr", 32'(busy), 32'h0);
    idle(); tick();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
